// File: rtl/m_fetch_queue_pkg.sv
// Shared fetch/decode definitions: halt word, opcode fields, queue entry payload.
package m_fetch_queue_pkg;

  localparam logic [31:0] HALT_INSTR = 32'h000f0033;

  // Major opcode field (instr[6:2]) values shared with decode/execute
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OP_IMM = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/m_fetch_fifo.sv
// Circular buffer of fetch entries with a registered head view and flush.
module m_fetch_fifo
  import m_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  fetch_entry_t             wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     out_valid,
  output fetch_entry_t             out_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t          mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [CW-1:0]         count_nxt;
  fetch_entry_t          head_nxt;

  // Next pointers/count and the entry that will sit at the head after this edge
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (wr_en) wr_ptr_nxt = wr_ptr + PW'(1);
      if (rd_en) rd_ptr_nxt = rd_ptr + PW'(1);
      count_nxt = count + CW'(wr_en) - CW'(rd_en);
    end
    // A write landing on the new head slot bypasses the array
    head_nxt = (wr_en && !flush && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered head; head data holds while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (count_nxt != '0) out_data <= head_nxt;
    end
  end

endmodule

// File: rtl/m_fetch_queue.sv
// Instruction prefetch queue: sequential imem reads, credit-limited buffering, redirect and halt.
module m_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 12,
  parameter logic [31:0] HALT_INSTR = m_fetch_queue_pkg::HALT_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [AW-1:0] imem_addr,
  output logic          imem_en,
  input  logic [31:0]   imem_data,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  output logic          halted
);

  import m_fetch_queue_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          pending;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight_c;
  logic          deq_c;
  logic          enq_c;
  fetch_entry_t  wr_data_c;
  fetch_entry_t  head;

  // Credit check: entries held plus the one in flight, less the one leaving now
  always_comb begin
    deq_c      = out_valid & out_ready;
    inflight_c = {1'b0, count} + IW'(pending) - IW'(deq_c);
    imem_en    = ce & ~rst & ~redirect & ~halted & (inflight_c < IW'(DEPTH));
    enq_c      = ce & pending & ~redirect & ~halted;
    wr_data_c  = '{pc: pend_pc, instr: imem_data};
    imem_addr  = fetch_pc[AW+1:2];
    out_pc     = head.pc;
    out_instr  = head.instr;
  end

  // Fetch PC, outstanding-read tracking and halt latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= '0;
      pend_pc  <= '0;
      pending  <= 1'b0;
      halted   <= 1'b0;
    end else if (ce) begin
      if (redirect) begin
        fetch_pc <= redirect_pc & 32'hffff_fffc;
        pending  <= 1'b0;
        halted   <= 1'b0;
      end else begin
        pending <= imem_en;
        if (imem_en) begin
          fetch_pc <= fetch_pc + 32'd4;
          pend_pc  <= fetch_pc;
        end
        if (enq_c && (imem_data == HALT_INSTR)) halted <= 1'b1;
      end
    end
  end

  m_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (enq_c),
    .wr_data   (wr_data_c),
    .rd_en     (ce & deq_c),
    .flush     (ce & redirect),
    .count     (count),
    .out_valid (out_valid),
    .out_data  (head)
  );

endmodule
